// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Shared core definitions: writeback source ids, load funct3 codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        WB_PC4 = 2'd0,
        WB_ALU = 2'd1,
        WB_DM  = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage : cpu_defs_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load lane select, sign/zero extension and
//               misalignment detection.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import cpu_defs_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    localparam int c_LANEW = (XLEN == 64) ? 3 : 2;

    logic [c_LANEW-1:0] w_lane;
    logic [XLEN-1:0]    w_shift;

    assign w_lane  = addr_lo[c_LANEW-1:0];
    // Addressed byte is moved to lane 0 before extension.
    assign w_shift = raw >> {w_lane, 3'b000};

    always_comb begin
        data     = w_shift;
        misalign = 1'b0;
        case (funct3)
            F3_LB:  data = XLEN'($signed(w_shift[7:0]));
            F3_LBU: data = XLEN'(w_shift[7:0]);
            F3_LH: begin
                data     = XLEN'($signed(w_shift[15:0]));
                misalign = addr_lo[0];
            end
            F3_LHU: begin
                data     = XLEN'(w_shift[15:0]);
                misalign = addr_lo[0];
            end
            F3_LW: begin
                data     = XLEN'($signed(w_shift[31:0]));
                misalign = |addr_lo[1:0];
            end
            F3_LWU: begin
                data     = XLEN'(w_shift[31:0]);
                misalign = |addr_lo[1:0];
            end
            F3_LD:   misalign = |addr_lo;
            default: data = raw;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pipe
// Description : Registered writeback stage: source mux, load alignment,
//               MEM/WB register, forwarding bus and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_pipe
    import cpu_defs_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NSRC     = 4,
    parameter int SELW     = $clog2(NSRC),
    parameter int LOAD_IDX = WB_DM,
    parameter int CNTW     = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [NSRC*XLEN-1:0] src_data,
    input  logic [SELW-1:0]      wb_sel,
    input  logic [4:0]           rd,
    input  logic                 rd_we,
    input  logic [2:0]           ld_funct3,
    input  logic [2:0]           ld_addr_lo,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 ld_misalign,
    output logic [CNTW-1:0]      retire_cnt
);

    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] w_ld_data;
    logic            w_ld_mis;
    logic            w_is_load;
    logic [XLEN-1:0] w_data;
    logic            w_misalign;
    logic            w_capture;

    logic            r_we;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            r_misalign;
    logic [CNTW-1:0] r_cnt;

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_src = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (wb_sel == SELW'(i)) w_src = src_data[i*XLEN +: XLEN];
        end
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .raw      (w_src),
        .funct3   (ld_funct3),
        .addr_lo  (ld_addr_lo),
        .data     (w_ld_data),
        .misalign (w_ld_mis)
    );

    assign w_is_load  = (wb_sel == SELW'(LOAD_IDX));
    assign w_data     = w_is_load ? w_ld_data : w_src;
    assign w_misalign = w_is_load & w_ld_mis;
    assign in_ready   = ~stall;
    assign w_capture  = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else if (stall) begin
            // Hold the write; only the misalign pulse is dropped.
            r_misalign <= 1'b0;
        end else if (w_capture) begin
            r_we       <= rd_we & (rd != 5'd0) & ~w_misalign;
            r_waddr    <= rd;
            r_wdata    <= w_data;
            r_misalign <= w_misalign;
            r_cnt      <= r_cnt + CNTW'(1);
        end else begin
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_misalign <= 1'b0;
        end
    end

    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign fwd_valid   = r_we;
    assign fwd_rd      = r_waddr;
    assign fwd_data    = r_wdata;
    assign ld_misalign = r_misalign;
    assign retire_cnt  = r_cnt;

endmodule : wb_stage_pipe
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_pipe
// Description : Scoreboard bench for wb_stage_pipe (XLEN=32, NSRC=3 so that
//               wb_sel=3 is out of range).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_pipe;
    import cpu_defs_pkg::*;

    localparam int XLEN = 32;
    localparam int NSRC = 3;
    localparam int SELW = 2;
    localparam int CNTW = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, stall, flush;
    logic [31:0]     s_pc4, s_alu, s_dm;
    logic [NSRC*XLEN-1:0] src_data;
    logic [SELW-1:0] wb_sel;
    logic [4:0]      rd;
    logic            rd_we;
    logic [2:0]      ld_funct3, ld_addr_lo;
    logic            rf_we, fwd_valid, ld_misalign;
    logic [4:0]      rf_waddr, fwd_rd;
    logic [31:0]     rf_wdata, fwd_data;
    logic [CNTW-1:0] retire_cnt;

    assign src_data = {s_dm, s_alu, s_pc4};

    wb_stage_pipe #(
        .XLEN(XLEN), .NSRC(NSRC), .SELW(SELW), .LOAD_IDX(2), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .src_data(src_data), .wb_sel(wb_sel),
        .rd(rd), .rd_we(rd_we), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .ld_misalign(ld_misalign), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
        logic [63:0] cnt;
        logic        dv;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        m_we, m_mis, m_dv;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [63:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] ld_model(input logic [31:0] dm, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        logic        mis;
        case (a)
            2'd0: begin b = dm[7:0];   h = dm[15:0];          end
            2'd1: begin b = dm[15:8];  h = dm[23:8];          end
            2'd2: begin b = dm[23:16]; h = dm[31:16];         end
            default: begin b = dm[31:24]; h = {8'h00, dm[31:24]}; end
        endcase
        mis = 1'b0;
        d   = dm;
        case (f3)
            F3_LB:  d = {{24{b[7]}}, b};
            F3_LBU: d = {24'h0, b};
            F3_LH:  begin d = {{16{h[15]}}, h}; mis = a[0]; end
            F3_LHU: begin d = {16'h0, h};       mis = a[0]; end
            F3_LW:  mis = (a != 2'd0);
            default: d = dm;
        endcase
        return {mis, d};
    endfunction

    // Inputs are already applied (just after a falling edge).
    task automatic cycle();
        exp_t        e;
        logic [32:0] lm;
        logic [31:0] d;
        logic        mis;
        #1;
        check("in_ready", {63'h0, in_ready}, {63'h0, ~stall});
        if (stall) begin
            m_mis = 1'b0;
        end else if (in_valid && !flush) begin
            mis = 1'b0;
            if (wb_sel == 2'd3) d = 32'h0;
            else if (wb_sel == 2'd2) begin
                lm  = ld_model(s_dm, ld_funct3, ld_addr_lo[1:0]);
                d   = lm[31:0];
                mis = lm[32];
            end else d = (wb_sel == 2'd0) ? s_pc4 : s_alu;
            m_we    = rd_we && (rd != 5'd0) && !mis;
            m_waddr = rd;
            m_wdata = d;
            m_mis   = mis;
            m_dv    = !mis;
            m_cnt   = m_cnt + 64'd1;
        end else begin
            m_we = 1'b0; m_mis = 1'b0; m_dv = 1'b0;
        end
        q.push_back('{m_we, m_waddr, m_wdata, m_mis, m_cnt, m_dv});
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("rf_we",       {63'h0, rf_we},       {63'h0, e.we});
        check("fwd_valid",   {63'h0, fwd_valid},   {63'h0, e.we});
        check("ld_misalign", {63'h0, ld_misalign}, {63'h0, e.mis});
        check("retire_cnt",  retire_cnt,           e.cnt);
        if (e.dv) begin
            check("rf_waddr", {59'h0, rf_waddr}, {59'h0, e.waddr});
            check("rf_wdata", {32'h0, rf_wdata}, {32'h0, e.wdata});
            check("fwd_rd",   {59'h0, fwd_rd},   {59'h0, e.waddr});
            check("fwd_data", {32'h0, fwd_data}, {32'h0, e.wdata});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic st, input logic fl, input logic [1:0] sel,
                         input logic [4:0] r, input logic we, input logic [2:0] f3,
                         input logic [2:0] a);
        in_valid = v; stall = st; flush = fl; wb_sel = sel;
        rd = r; rd_we = we; ld_funct3 = f3; ld_addr_lo = a;
        cycle();
    endtask

    task automatic model_reset();
        m_we = 1'b0; m_mis = 1'b0; m_dv = 1'b0;
        m_waddr = '0; m_wdata = '0; m_cnt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3_tab [5];
        f3_tab = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        rst_n = 1'b0;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; wb_sel = '0;
        rd = '0; rd_we = 1'b0; ld_funct3 = '0; ld_addr_lo = '0;
        s_pc4 = 32'h0000_1004; s_alu = 32'h0; s_dm = 32'h0;
        model_reset();
        #2;
        check("rst_rf_we",    {63'h0, rf_we},    64'h0);
        check("rst_rf_wdata", {32'h0, rf_wdata}, 64'h0);
        check("rst_cnt",      retire_cnt,        64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-operation, asserted between edges
        s_alu = 32'hAAAA_5555;
        drive(1, 0, 0, WB_ALU, 5'd3, 1, F3_LW, 3'd0);
        rst_n = 1'b0;
        #1;
        check("amid_rf_we",    {63'h0, rf_we},    64'h0);
        check("amid_rf_wdata", {32'h0, rf_wdata}, 64'h0);
        check("amid_cnt",      retire_cnt,        64'h0);
        model_reset();
        #1 rst_n = 1'b1;

        // ALU write
        s_alu = 32'h1234_5678;
        drive(1, 0, 0, WB_ALU, 5'd5, 1, F3_LW, 3'd0);
        check("alu_data", {32'h0, rf_wdata}, 64'h1234_5678);
        check("alu_cnt",  retire_cnt,        64'd1);

        // Load extension
        s_dm = 32'h80FF_7F01;
        drive(1, 0, 0, WB_DM, 5'd6, 1, F3_LB, 3'd3);
        check("lb_a3",  {32'h0, rf_wdata}, 64'hFFFF_FF80);
        drive(1, 0, 0, WB_DM, 5'd6, 1, F3_LBU, 3'd1);
        check("lbu_a1", {32'h0, rf_wdata}, 64'h0000_007F);
        drive(1, 0, 0, WB_DM, 5'd6, 1, F3_LH, 3'd2);
        check("lh_a2",  {32'h0, rf_wdata}, 64'hFFFF_80FF);

        // Misaligned word load, then a bubble
        drive(1, 0, 0, WB_DM, 5'd6, 1, F3_LW, 3'd2);
        check("lw_mis_pulse", {63'h0, ld_misalign}, 64'h1);
        check("lw_mis_cnt",   retire_cnt,           64'd5);
        drive(0, 0, 0, WB_ALU, 5'd0, 0, F3_LW, 3'd0);

        // Capture then stall for 3 cycles with fresh inputs
        s_alu = 32'hCAFE_F00D;
        drive(1, 0, 0, WB_ALU, 5'd7, 1, F3_LW, 3'd0);
        for (int i = 0; i < 3; i++) begin
            s_alu = 32'h1111_0000 + 32'(i);
            drive(1, 1, 0, WB_ALU, 5'd9, 1, F3_LW, 3'd0);
            check("stall_hold", {32'h0, rf_wdata}, 64'hCAFE_F00D);
        end

        // Flush beats capture; out-of-range select with rd=0
        drive(1, 0, 1, WB_ALU, 5'd8, 1, F3_LW, 3'd0);
        check("flush_cnt", retire_cnt, 64'd6);
        drive(1, 0, 0, 2'd3, 5'd0, 1, F3_LW, 3'd0);
        check("oor_data", {32'h0, rf_wdata}, 64'h0);
        check("oor_we",   {63'h0, rf_we},    64'h0);

        for (int i = 0; i < 200; i++) begin
            s_pc4 = $urandom; s_alu = $urandom; s_dm = $urandom;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 6) == 0), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  f3_tab[$urandom_range(0, 4)], 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wb_stage_pipe
`default_nettype wire
